vr_hw2_mem_access_unit: RTL and testbench
=========================================

// Module: vr_hw2_mem_access_unit
// PURPOSE
//  Load/store unit between the datapath and the word-only, level-sensitive data memory.
//  Accepts byte, half and word loads/stores and runs read-modify-write for sub-word stores.
//  Sign- or zero-extends load data and flags misaligned or out-of-range accesses.
//  All memory-side outputs are registered, so the memory never sees a glitching write.
// PARAMETERS
//  ADDR_LIMIT  1024  byte-address bound; an access is legal only if ADDR < ADDR_LIMIT (full 32-bit compare)
// PORTS
//  CLK      in   1   clock, rising edge
//  RST_N    in   1   asynchronous active-low reset
//  REQ      in   1   request valid; sampled only in IDLE
//  WE       in   1   0 = load, 1 = store
//  SIZE     in   2   00 byte, 01 half, 10 word, 11 illegal
//  SIGNED   in   1   load extension: 1 = sign, 0 = zero
//  ADDR     in   32  byte address
//  WDATA    in   32  store data, right-aligned (byte in [7:0], half in [15:0])
//  BUSY     out  1   high in every state except IDLE
//  DONE     out  1   one-cycle completion pulse
//  RDATA    out  32  extended load result; valid while DONE=1; 0 for stores and faults
//  FAULT    out  1   valid while DONE=1; misaligned, illegal SIZE or out of range
//  MEM_ADDR out  32  to memory ADDR
//  MEM_RW   out  1   to memory RW (1 = write)
//  MEM_WD   out  32  to memory WD
//  MEM_RD   in   32  from memory RD (combinational, valid in the same cycle when MEM_RW=0)
// BEHAVIOUR
//  Reset: state IDLE, and every output (BUSY, DONE, RDATA, FAULT, MEM_ADDR, MEM_RW, MEM_WD) is 0 immediately.
//  FSM: IDLE, READ, WRITE, RESP.
//   IDLE:  on REQ, latch ADDR, WE, SIZE, SIGNED and WDATA, then select the next state:
//          - fault -> RESP with FAULT=1; memory is never touched
//          - load or sub-word store -> READ
//          - word store -> WRITE
//          Fault conditions: SIZE=11, half with ADDR[0]=1, word with ADDR[1:0]!=0, or ADDR>=ADDR_LIMIT.
//   READ:  MEM_ADDR = {latched ADDR[31:2], 2'b00}, MEM_RW=0; register MEM_RD at the clock edge.
//          Load -> RESP. Sub-word store -> WRITE, with MEM_WD = the merged word.
//   WRITE: MEM_RW=1 for exactly one cycle; MEM_ADDR and MEM_WD are stable for that whole cycle -> RESP.
//   RESP:  DONE=1 for one cycle, RDATA and FAULT driven, then -> IDLE. Outputs clear to 0 in IDLE.
//  MEM_RW is 1 only in WRITE and is driven directly from a flop. MEM_ADDR holds its last value outside READ/WRITE.
//  Byte lanes are little-endian: byte k = bits[8k+7:8k] with k = ADDR[1:0]; half h = bits[16h+15:16h] with h = ADDR[1].
//  Merge: only the addressed lane is replaced with WDATA[7:0] or WDATA[15:0]; the other lanes keep the MEM_RD value.
//  Load extraction: the lane is right-aligned, then extended per SIGNED. Word loads ignore SIGNED.
//  Latency (REQ edge to DONE high):
//    fault                 1 cycle
//    load / word store     2 cycles
//    sub-word store        3 cycles
//  REQ while BUSY=1 is ignored and not queued; the next request can be accepted on the cycle after DONE.
//  Reset mid-operation: MEM_RW drops asynchronously and no DONE is issued.
//  If reset hits during WRITE, the target word may already hold MEM_WD; no further write occurs.
// TESTING
//  T1 reset: RST_N=0 asynchronously during READ -> all outputs 0 before the next edge; state IDLE after release.
//  T2 store word ADDR=0x10, WDATA=0xDEADBEEF -> MEM_RW=1 for one cycle with MEM_WD=0xDEADBEEF, DONE at +2;
//     then load word 0x10 -> RDATA=0xDEADBEEF at +2.
//  T3 store byte 0xA5 to 0x11 over 0xDEADBEEF -> READ then WRITE with MEM_WD=0xDEADA5EF, DONE at +3.
//  T4 load byte 0x11 with SIGNED=1 -> 0xFFFFFFA5; with SIGNED=0 -> 0x000000A5;
//     load half 0x12 with SIGNED=1 -> 0xFFFFDEAD.
//  T5 load word 0x13 and load byte 0x400 -> FAULT=1, DONE at +1, RDATA=0, MEM_RW never 1.
//  T6 REQ held high throughout a store -> exactly one MEM_RW pulse;
//     RST_N=0 during WRITE -> MEM_RW falls immediately and no DONE is issued.

Source files
------------

// File: rtl/vr_hw2_mem_access_unit_if.sv
// Datapath request/response and word-memory signals of the load/store unit.
// The master side is the datapath plus the memory; the slave side is the unit itself.
interface vr_hw2_mem_access_unit_if;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          req;
    logic          we;
    logic [1:0]    sz;
    logic          sgn;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          busy;
    logic          done;
    logic [DW-1:0] rdata;
    logic          fault;
    logic [AW-1:0] mem_addr;
    logic          mem_rw;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem_rd;

    modport master (
        output req, we, sz, sgn, addr, wdata, mem_rd,
        input  busy, done, rdata, fault, mem_addr, mem_rw, mem_wd
    );

    modport slave (
        input  req, we, sz, sgn, addr, wdata, mem_rd,
        output busy, done, rdata, fault, mem_addr, mem_rw, mem_wd
    );
endinterface

// File: rtl/vr_hw2_mem_access_unit.sv
// Load/store unit for a word-only memory: sub-word stores use read-modify-write,
// loads are lane-extracted and extended; every output comes straight from a flop.
module vr_hw2_mem_access_unit #(
    parameter logic [31:0] ADDR_LIMIT = 32'd1024
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    vr_hw2_mem_access_unit_if.slave       io_bus
);
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam logic [1:0]  SZ_BYTE = 2'b00;
    localparam logic [1:0]  SZ_HALF = 2'b01;
    localparam logic [1:0]  SZ_WORD = 2'b10;
    localparam logic [1:0]  SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

    state_t        r_state,    w_state_nxt;
    logic          r_we,       w_we_nxt;
    logic          r_sgn,      w_sgn_nxt;
    logic [1:0]    r_size,     w_size_nxt;
    logic [AW-1:0] r_addr,     w_addr_nxt;
    logic [15:0]   r_wdata,    w_wdata_nxt;
    logic          r_busy,     w_busy_nxt;
    logic          r_done,     w_done_nxt;
    logic          r_fault,    w_fault_nxt;
    logic [DW-1:0] r_rdata,    w_rdata_nxt;
    logic [AW-1:0] r_mem_addr, w_mem_addr_nxt;
    logic          r_mem_rw,   w_mem_rw_nxt;
    logic [DW-1:0] r_mem_wd,   w_mem_wd_nxt;

    logic          w_req_fault;
    logic [4:0]    w_bsh;
    logic [4:0]    w_hsh;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [DW-1:0] w_merged;
    logic [DW-1:0] w_load;

    assign w_req_fault = (io_bus.sz == SZ_ILL)
                       || ((io_bus.sz == SZ_HALF) && io_bus.addr[0])
                       || ((io_bus.sz == SZ_WORD) && (io_bus.addr[1:0] != 2'b00))
                       || (io_bus.addr >= ADDR_LIMIT);

    assign w_bsh  = {r_addr[1:0], 3'b000};
    assign w_hsh  = {r_addr[1], 4'b0000};
    assign w_byte = io_bus.mem_rd[w_bsh +: 8];
    assign w_half = io_bus.mem_rd[w_hsh +: 16];

    // Lane merge for sub-word stores and lane extraction for loads
    always_comb begin
        w_merged = io_bus.mem_rd;
        w_load   = io_bus.mem_rd;
        case (r_size)
            SZ_BYTE: begin
                w_merged[w_bsh +: 8]  = r_wdata[7:0];
                w_load                = {{24{r_sgn & w_byte[7]}}, w_byte};
            end
            SZ_HALF: begin
                w_merged[w_hsh +: 16] = r_wdata;
                w_load                = {{16{r_sgn & w_half[15]}}, w_half};
            end
            default: ;
        endcase
    end

    // Next state and next registered outputs
    always_comb begin
        w_state_nxt    = r_state;
        w_we_nxt       = r_we;
        w_sgn_nxt      = r_sgn;
        w_size_nxt     = r_size;
        w_addr_nxt     = r_addr;
        w_wdata_nxt    = r_wdata;
        w_done_nxt     = 1'b0;
        w_fault_nxt    = r_fault;
        w_rdata_nxt    = r_rdata;
        w_mem_addr_nxt = r_mem_addr;
        w_mem_rw_nxt   = 1'b0;
        w_mem_wd_nxt   = r_mem_wd;

        unique case (r_state)
            S_IDLE: begin
                w_fault_nxt = 1'b0;
                w_rdata_nxt = '0;
                if (io_bus.req) begin
                    w_we_nxt    = io_bus.we;
                    w_sgn_nxt   = io_bus.sgn;
                    w_size_nxt  = io_bus.sz;
                    w_addr_nxt  = io_bus.addr;
                    w_wdata_nxt = io_bus.wdata[15:0];
                    if (w_req_fault) begin
                        w_state_nxt = S_RESP;
                        w_fault_nxt = 1'b1;
                        w_done_nxt  = 1'b1;
                    end else if (io_bus.we && (io_bus.sz == SZ_WORD)) begin
                        w_state_nxt    = S_WRITE;
                        w_mem_addr_nxt = {io_bus.addr[AW-1:2], 2'b00};
                        w_mem_wd_nxt   = io_bus.wdata;
                        w_mem_rw_nxt   = 1'b1;
                    end else begin
                        w_state_nxt    = S_READ;
                        w_mem_addr_nxt = {io_bus.addr[AW-1:2], 2'b00};
                    end
                end
            end
            S_READ: begin
                w_mem_addr_nxt = {r_addr[AW-1:2], 2'b00};
                if (r_we) begin
                    w_state_nxt  = S_WRITE;
                    w_mem_wd_nxt = w_merged;
                    w_mem_rw_nxt = 1'b1;
                end else begin
                    w_state_nxt = S_RESP;
                    w_rdata_nxt = w_load;
                    w_done_nxt  = 1'b1;
                end
            end
            S_WRITE: begin
                w_state_nxt = S_RESP;
                w_rdata_nxt = '0;
                w_done_nxt  = 1'b1;
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
                w_rdata_nxt = '0;
                w_fault_nxt = 1'b0;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_we       <= 1'b0;
            r_sgn      <= 1'b0;
            r_size     <= 2'b00;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_fault    <= 1'b0;
            r_rdata    <= '0;
            r_mem_addr <= '0;
            r_mem_rw   <= 1'b0;
            r_mem_wd   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_we       <= w_we_nxt;
            r_sgn      <= w_sgn_nxt;
            r_size     <= w_size_nxt;
            r_addr     <= w_addr_nxt;
            r_wdata    <= w_wdata_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_fault    <= w_fault_nxt;
            r_rdata    <= w_rdata_nxt;
            r_mem_addr <= w_mem_addr_nxt;
            r_mem_rw   <= w_mem_rw_nxt;
            r_mem_wd   <= w_mem_wd_nxt;
        end
    end

    assign io_bus.busy     = r_busy;
    assign io_bus.done     = r_done;
    assign io_bus.fault    = r_fault;
    assign io_bus.rdata    = r_rdata;
    assign io_bus.mem_addr = r_mem_addr;
    assign io_bus.mem_rw   = r_mem_rw;
    assign io_bus.mem_wd   = r_mem_wd;
endmodule

// File: tb/tb_vr_hw2_mem_access_unit.sv
// Scoreboard bench for the load/store unit: directed requests push expected responses
// and memory writes; negedge monitors pop and compare whenever DONE or MEM_RW is seen.
module tb_vr_hw2_mem_access_unit;
    typedef struct {logic [31:0] rdata; logic fault; int lat; int t0;} resp_t;
    typedef struct {logic [31:0] addr; logic [31:0] wd;} wr_t;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    resp_t rq[$];
    wr_t   wq[$];
    logic [31:0] mem [0:255];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vr_hw2_mem_access_unit_if bus();

    vr_hw2_mem_access_unit #(.ADDR_LIMIT(32'd1024)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (bus)
    );

    // Word memory: combinational read, write at the clock edge while MEM_RW=1
    assign bus.mem_rd = mem[bus.mem_addr[9:2]];
    always @(posedge clk) if (bus.mem_rw) mem[bus.mem_addr[9:2]] <= bus.mem_wd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_zero(input string p);
        chk({p, "_busy"},     32'(bus.busy),   32'd0);
        chk({p, "_done"},     32'(bus.done),   32'd0);
        chk({p, "_rdata"},    bus.rdata,       32'd0);
        chk({p, "_fault"},    32'(bus.fault),  32'd0);
        chk({p, "_mem_addr"}, bus.mem_addr,    32'd0);
        chk({p, "_mem_rw"},   32'(bus.mem_rw), 32'd0);
        chk({p, "_mem_wd"},   bus.mem_wd,      32'd0);
    endtask

    // Response and write monitors
    resp_t e;
    wr_t   w;
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            if (rq.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
            end else begin
                e = rq.pop_front();
                chk("rdata",   bus.rdata,          e.rdata);
                chk("fault",   32'(bus.fault),     32'(e.fault));
                chk("latency", 32'(cyc - e.t0),    32'(e.lat));
            end
        end
        if (rst_n && bus.mem_rw) begin
            if (wq.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_write: got mem_rw=1 addr %h wd %h expected none", bus.mem_addr, bus.mem_wd);
            end else begin
                w = wq.pop_front();
                chk("mem_addr", bus.mem_addr, w.addr);
                chk("mem_wd",   bus.mem_wd,   w.wd);
            end
        end
    end

    // Issue one request at a negedge and wait (bounded) for its DONE
    task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_f, input int lat,
                         input logic exp_wr, input logic [31:0] wr_a, input logic [31:0] wr_d,
                         input logic hold);
        logic got;
        bus.req = 1'b1; bus.we = we; bus.sz = sz; bus.sgn = sg; bus.addr = a; bus.wdata = wd;
        rq.push_back('{exp_rd, exp_f, lat, cyc});
        if (exp_wr) wq.push_back('{wr_a, wr_d});
        @(posedge clk); #1;
        if (!hold) bus.req = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (bus.done) got = 1'b1;
        end
        bus.req = 1'b0;
        if (!got) begin
            total++; bad++;
            $display("FAIL done_timeout: got no done expected done for addr %h", a);
            rq.delete(); wq.delete();
        end
        @(negedge clk);
    endtask

    task automatic ld(input logic [1:0] sz, input logic sg, input logic [31:0] a,
                      input logic [31:0] exp_rd, input logic exp_f, input int lat);
        issue(1'b0, sz, sg, a, 32'h0, exp_rd, exp_f, lat, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic st(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                      input logic exp_f, input int lat, input logic [31:0] wr_a,
                      input logic [31:0] wr_d, input logic hold);
        issue(1'b1, sz, 1'b0, a, wd, 32'h0, exp_f, lat, !exp_f, wr_a, wr_d, hold);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        bus.req = 1'b0; bus.we = 1'b0; bus.sz = 2'b00; bus.sgn = 1'b0;
        bus.addr = 32'h0; bus.wdata = 32'h0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 chk_zero("por");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);

        // Word store then word load
        st(2'b10, 32'h10, 32'hDEADBEEF, 1'b0, 2, 32'h10, 32'hDEADBEEF, 1'b0);
        ld(2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 2);
        // Byte store via read-modify-write
        st(2'b00, 32'h11, 32'h123456A5, 1'b0, 3, 32'h10, 32'hDEADA5EF, 1'b0);
        // Extension and lane selection
        ld(2'b00, 1'b1, 32'h11, 32'hFFFFFFA5, 1'b0, 2);
        ld(2'b00, 1'b0, 32'h11, 32'h000000A5, 1'b0, 2);
        ld(2'b01, 1'b1, 32'h12, 32'hFFFFDEAD, 1'b0, 2);
        ld(2'b01, 1'b0, 32'h10, 32'h0000A5EF, 1'b0, 2);
        ld(2'b00, 1'b1, 32'h13, 32'hFFFFFFDE, 1'b0, 2);
        ld(2'b10, 1'b1, 32'h10, 32'hDEADA5EF, 1'b0, 2);
        // Half store into upper lane
        st(2'b01, 32'h12, 32'hFFFF1234, 1'b0, 3, 32'h10, 32'h1234A5EF, 1'b0);
        ld(2'b10, 1'b0, 32'h10, 32'h1234A5EF, 1'b0, 2);
        // Faults: misaligned, out of range, illegal size
        ld(2'b10, 1'b0, 32'h13, 32'h0, 1'b1, 1);
        ld(2'b00, 1'b0, 32'h400, 32'h0, 1'b1, 1);
        ld(2'b11, 1'b0, 32'h10, 32'h0, 1'b1, 1);
        st(2'b01, 32'h11, 32'hFFFF, 1'b1, 1, 32'h0, 32'h0, 1'b0);
        ld(2'b10, 1'b0, 32'hFFFFFFFC, 32'h0, 1'b1, 1);
        // Last legal word
        st(2'b10, 32'h3FC, 32'h80112233, 1'b0, 2, 32'h3FC, 32'h80112233, 1'b0);
        ld(2'b00, 1'b1, 32'h3FF, 32'hFFFFFF80, 1'b0, 2);
        ld(2'b00, 1'b0, 32'h3FE, 32'h00000011, 1'b0, 2);
        // REQ held through a sub-word store: one write, one DONE
        st(2'b00, 32'h21, 32'h00000077, 1'b0, 3, 32'h20, 32'h00007700, 1'b1);
        chk("hold_mem", mem[8], 32'h00007700);

        // Reset during WRITE: MEM_RW drops at once, no DONE, no write
        bus.req = 1'b1; bus.we = 1'b1; bus.sz = 2'b10; bus.addr = 32'h30; bus.wdata = 32'hCAFEF00D;
        @(posedge clk); #1 bus.req = 1'b0;
        chk("wr_rw_high", 32'(bus.mem_rw), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk("wr_rst_rw", 32'(bus.mem_rw), 32'd0);
        chk("wr_rst_done", 32'(bus.done), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("wr_rst_mem", mem[12], 32'h0);

        // Reset during READ: all outputs clear before the next edge
        bus.req = 1'b1; bus.we = 1'b0; bus.sz = 2'b10; bus.addr = 32'h10;
        @(posedge clk); #1 bus.req = 1'b0;
        chk("rd_busy", 32'(bus.busy), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk_zero("rd_rst");
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rd_idle_busy", 32'(bus.busy), 32'd0);
        ld(2'b10, 1'b0, 32'h10, 32'h1234A5EF, 1'b0, 2);

        repeat (3) @(negedge clk);
        chk("resp_queue_empty", 32'(rq.size()), 32'd0);
        chk("write_queue_empty", 32'(wq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
